// File: rtl/golomb_sched.sv
// -----------------------------------------------------------------------------
// golomb_sched
//
// Shares one Golomb-Rice coder between two requesters:
//   requester 0 : regular-mode mapped residual (limit fixed at LIMIT)
//   requester 1 : run-interruption mapped residual (limit supplied as limit1)
// Requests are arbitrated round-robin in IDLE. The winner's operands are
// latched, then k is found by an iterative search, one compare per cycle:
// the smallest k with (n << k) >= a, capped at KMAX. One single-cycle coder
// enable (g_en) is issued per granted request.
//
// Handshake: a requester raises reqX together with its data and holds both
// until it sees gntX (a one-cycle pulse in the cycle after the sampling edge).
// It must drop reqX during that gnt cycle; a reqX still high when the block
// returns to IDLE is taken as a new request. Requests are sampled only in IDLE.
// Per-item period is k+3 cycles: gnt after E0, g_en after E(k+1), IDLE again
// at E(k+2), next request sampled at E(k+3).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clr        synchronous clear (frame start): abort and return to IDLE
//   req0/req1  request lines; merrX/aX/nX per-requester operands; limit1
//   gnt0/gnt1  one-cycle accept pulses
//   g_en       coder enable; g_merr/g_k/g_limit/g_src valid with it, else 0
//   busy       registered (state != IDLE)
//   state_dbg  current FSM state (0 IDLE, 1 KCALC, 2 ISSUE)
// -----------------------------------------------------------------------------
module golomb_sched #(
   parameter int LIMIT = 32,
   parameter int KMAX  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       req0,
   input  logic [8:0] merr0,
   input  logic [15:0] a0,
   input  logic [6:0] n0,
   input  logic       req1,
   input  logic [8:0] merr1,
   input  logic [15:0] a1,
   input  logic [6:0] n1,
   input  logic [5:0] limit1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       g_en,
   output logic [8:0] g_merr,
   output logic [4:0] g_k,
   output logic [5:0] g_limit,
   output logic       g_src,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam logic [4:0] K_MAX = 5'(KMAX);
   localparam logic [5:0] LIM0  = 6'(LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KCALC = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  k, k_nxt;
   logic        last, last_nxt;
   logic        src, src_nxt;
   logic [8:0]  merr_q, merr_q_nxt;
   logic [15:0] a_q, a_q_nxt;
   logic [6:0]  n_q, n_q_nxt;
   logic [5:0]  limit_q, limit_q_nxt;

   logic        gnt0_nxt, gnt1_nxt, g_en_nxt, g_src_nxt, busy_nxt;
   logic [8:0]  g_merr_nxt;
   logic [4:0]  g_k_nxt;
   logic [5:0]  g_limit_nxt;

   logic        win;
   logic [23:0] n_shift;
   logic        k_done;

   // With both requests pending, the side that was not served last wins.
   // last resets to 1 so requester 0 wins the first tie.
   assign win = (req0 && req1) ? ~last : req1;

   // Unsigned 24-bit compare; n is zero-extended before the shift so no bits
   // are lost for any k up to 16.
   assign n_shift = {17'd0, n_q} << k;
   assign k_done  = (n_shift >= {8'd0, a_q}) || (k == K_MAX);

   assign state_dbg = state;

   always_comb begin
      state_nxt   = state;
      k_nxt       = k;
      last_nxt    = last;
      src_nxt     = src;
      merr_q_nxt  = merr_q;
      a_q_nxt     = a_q;
      n_q_nxt     = n_q;
      limit_q_nxt = limit_q;
      gnt0_nxt    = 1'b0;
      gnt1_nxt    = 1'b0;
      g_en_nxt    = 1'b0;
      g_merr_nxt  = 9'd0;
      g_k_nxt     = 5'd0;
      g_limit_nxt = 6'd0;
      g_src_nxt   = 1'b0;

      if (clr) begin
         // In-flight item is dropped; last is kept so fairness survives a clear.
         state_nxt = IDLE;
         k_nxt     = 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  src_nxt     = win;
                  last_nxt    = win;
                  merr_q_nxt  = win ? merr1 : merr0;
                  a_q_nxt     = win ? a1 : a0;
                  n_q_nxt     = win ? n1 : n0;
                  limit_q_nxt = win ? limit1 : LIM0;
                  k_nxt       = 5'd0;
                  gnt0_nxt    = ~win;
                  gnt1_nxt    = win;
                  state_nxt   = KCALC;
               end
            end
            KCALC: begin
               if (k_done) begin
                  g_en_nxt    = 1'b1;
                  g_k_nxt     = k;
                  g_merr_nxt  = merr_q;
                  g_limit_nxt = limit_q;
                  g_src_nxt   = src;
                  state_nxt   = ISSUE;
               end else begin
                  k_nxt = k + 5'd1;
               end
            end
            ISSUE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         k       <= 5'd0;
         last    <= 1'b1;
         src     <= 1'b0;
         merr_q  <= 9'd0;
         a_q     <= 16'd0;
         n_q     <= 7'd0;
         limit_q <= 6'd0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         g_en    <= 1'b0;
         g_merr  <= 9'd0;
         g_k     <= 5'd0;
         g_limit <= 6'd0;
         g_src   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         k       <= k_nxt;
         last    <= last_nxt;
         src     <= src_nxt;
         merr_q  <= merr_q_nxt;
         a_q     <= a_q_nxt;
         n_q     <= n_q_nxt;
         limit_q <= limit_q_nxt;
         gnt0    <= gnt0_nxt;
         gnt1    <= gnt1_nxt;
         g_en    <= g_en_nxt;
         g_merr  <= g_merr_nxt;
         g_k     <= g_k_nxt;
         g_limit <= g_limit_nxt;
         g_src   <= g_src_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_golomb_sched.sv
// -----------------------------------------------------------------------------
// tb_golomb_sched
//
// Directed bench for golomb_sched. Expected grants and expected coder items
// are pushed into queues by the stimulus; a monitor on the falling edge pops
// and compares whenever gnt0/gnt1 or g_en is seen, including the g_en latency
// (k+1 edges after the grant edge) and, where enabled, the g_en period.
// -----------------------------------------------------------------------------
module tb_golomb_sched;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   always #5 clk = ~clk;

   logic       clr = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [8:0] merr0 = '0, merr1 = '0;
   logic [15:0] a0 = '0, a1 = '0;
   logic [6:0] n0 = '0, n1 = '0;
   logic [5:0] limit1 = '0;
   logic       gnt0, gnt1, g_en, g_src, busy;
   logic [8:0] g_merr;
   logic [4:0] g_k;
   logic [5:0] g_limit;
   logic [1:0] state_dbg;

   golomb_sched #(.LIMIT(32), .KMAX(15)) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .req0(req0), .merr0(merr0), .a0(a0), .n0(n0),
      .req1(req1), .merr1(merr1), .a1(a1), .n1(n1), .limit1(limit1),
      .gnt0(gnt0), .gnt1(gnt1), .g_en(g_en), .g_merr(g_merr), .g_k(g_k),
      .g_limit(g_limit), .g_src(g_src), .busy(busy), .state_dbg(state_dbg)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic       exp_gnt_q[$];     // expected grant order (src)
   logic [20:0] exp_q[$];        // {merr[8:0], k[4:0], limit[5:0], src}
   int gnt_cyc = 0;
   int prev_en_cyc = -1;
   int exp_period = 0;           // 0: period not checked

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [20:0] item(input int merr, input int k, input int lim, input int src);
      return {9'(merr), 5'(k), 6'(lim), 1'(src)};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (gnt0 && gnt1) fail("gnt_both");
         if (gnt0 || gnt1) begin
            if (exp_gnt_q.size() == 0) fail("gnt_unexpected");
            else check("gnt_src", int'(gnt1), int'(exp_gnt_q.pop_front()));
            gnt_cyc = cyc;
         end
         if (g_en) begin
            if (exp_q.size() == 0) fail("g_en_unexpected");
            else begin
               logic [20:0] e;
               e = exp_q.pop_front();
               check("g_merr", int'(g_merr), int'(e[20:12]));
               check("g_k", int'(g_k), int'(e[11:7]));
               check("g_limit", int'(g_limit), int'(e[6:1]));
               check("g_src", int'(g_src), int'(e[0]));
               check("g_en_latency", cyc - gnt_cyc, int'(e[11:7]) + 1);
            end
            if (exp_period != 0 && prev_en_cyc >= 0)
               check("g_en_period", cyc - prev_en_cyc, exp_period);
            prev_en_cyc = cyc;
         end else begin
            check("g_idle_zero", int'({g_merr, g_k, g_limit, g_src}), 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req0(input int m, input int a, input int n);
      merr0 = 9'(m); a0 = 16'(a); n0 = 7'(n); req0 = 1'b1;
   endtask

   task automatic set_req1(input int m, input int a, input int n, input int lim);
      merr1 = 9'(m); a1 = 16'(a); n1 = 7'(n); limit1 = 6'(lim); req1 = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Waits for n grants, optionally dropping each req in its gnt cycle, then
   // drops all reqs and waits for the block to go idle with all items seen.
   task automatic run_grants(input int n, input bit drop);
      int seen = 0;
      int t = 0;
      while (seen < n && t < 400) begin
         @(negedge clk);
         t++;
         if (gnt0 || gnt1) begin
            seen++;
            check("busy_at_gnt", int'(busy), 1);
            if (drop) begin
               if (gnt0) req0 = 1'b0;
               if (gnt1) req1 = 1'b0;
            end
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      if (seen < n) fail("grant_timeout");
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) fail("idle_timeout");
   endtask

   task automatic wait_gnt0();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!gnt0 && t < 100);
      if (!gnt0) fail("gnt0_timeout");
      req0 = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", int'({gnt0, gnt1, g_en, g_merr, g_k, g_limit, g_src, busy}), 0);
      check("reset_state", int'(state_dbg), 0);
      reset = 1'b1;

      // Basic item: 4<<4 = 64 >= 40 is the first hit, so k=4.
      @(negedge clk);
      exp_gnt_q.push_back(1'b0);
      exp_q.push_back(item(37, 4, 32, 0));
      set_req0(37, 40, 4);
      run_grants(1, 1'b1);

      // Both held continuously, k=0: alternate 0,1,0,1 every 3 cycles.
      apply_reset();
      exp_period = 3; prev_en_cyc = -1;
      for (int i = 0; i < 2; i++) begin
         exp_gnt_q.push_back(1'b0);
         exp_gnt_q.push_back(1'b1);
         exp_q.push_back(item(100, 0, 32, 0));
         exp_q.push_back(item(200, 0, 23, 1));
      end
      set_req0(100, 1, 1);
      set_req1(200, 1, 1, 23);
      run_grants(4, 1'b0);
      exp_period = 0;

      // k search corners.
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(1, 0, 32, 0));
      set_req0(1, 0, 5);
      run_grants(1, 1'b1);
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(2, 15, 32, 0));
      set_req0(2, 65535, 1);
      run_grants(1, 1'b1);
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(3, 15, 32, 0));
      set_req0(3, 100, 0);
      run_grants(1, 1'b1);
      // Requester 1 alone, k=3 (1<<3 = 8 >= 5).
      exp_gnt_q.push_back(1'b1); exp_q.push_back(item(511, 3, 17, 1));
      set_req1(511, 5, 1, 17);
      run_grants(1, 1'b1);

      // clr mid-KCALC (k would reach 10): no g_en, idle next cycle.
      exp_gnt_q.push_back(1'b0);
      set_req0(5, 1000, 1);
      wait_gnt0();
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_busy", int'(busy), 0);
      check("clr_state", int'(state_dbg), 0);
      check("clr_g_en", int'(g_en), 0);
      repeat (15) @(negedge clk);
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(37, 4, 32, 0));
      set_req0(37, 40, 4);
      run_grants(1, 1'b1);

      // Re-assert right after gnt: second g_en exactly k+3 = 7 cycles later.
      exp_period = 7; prev_en_cyc = -1;
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(60, 4, 32, 0));
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(61, 4, 32, 0));
      set_req0(60, 40, 4);
      wait_gnt0();
      @(negedge clk);
      set_req0(61, 40, 4);
      run_grants(1, 1'b1);
      exp_period = 0;

      // Reset mid-KCALC: outputs clear at once; afterwards requester 0 first.
      exp_gnt_q.push_back(1'b0);
      set_req0(9, 1000, 1);
      wait_gnt0();
      @(negedge clk);
      set_req1(11, 1, 1, 20);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_reset_outputs", int'({gnt0, gnt1, g_en, g_merr, g_k, g_limit, g_src, busy}), 0);
      check("async_reset_state", int'(state_dbg), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_gnt_q.push_back(1'b0); exp_q.push_back(item(13, 0, 32, 0));
      exp_gnt_q.push_back(1'b1); exp_q.push_back(item(11, 0, 20, 1));
      set_req0(13, 1, 1);
      run_grants(2, 1'b1);

      repeat (3) @(negedge clk);
      check("gnt_queue_empty", exp_gnt_q.size(), 0);
      check("item_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
